icache_dm: RTL and testbench
============================

# icache_dm

Read-only, direct-mapped instruction cache that sits between the pipeline's `ICACHE_*` port and the instruction memory. It serves 32-bit instruction words to the fetch stage with zero added latency on a hit. On a miss it stalls the pipeline and refills a full 128-bit line from memory through a request/ready handshake. Writes are not supported: the pipeline ties `ICACHE_wen` low.

## Interface
- `NUM_BLOCKS`, default 8: number of lines; must be a power of two. Index width is `IW = log2(NUM_BLOCKS)`.
- Line size is fixed at 4 words (128 bits). Tag width is `28 - IW` bits (25 bits at default).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `proc_read`  in  1  fetch request; driven by `ICACHE_ren`.
- `proc_write`  in  1  driven by `ICACHE_wen`; ignored by the cache.
- `proc_addr`  in  30  word address. Fields: `[1:0]` word offset, `[IW+1:2]` index, `[29:IW+2]` tag.
- `proc_wdata`  in  32  unused.
- `proc_stall`  out  1  high means `proc_rdata` is not valid this cycle.
- `proc_rdata`  out  32  instruction word.
- `mem_read`  out  1  line refill request.
- `mem_write`  out  1  constant 0.
- `mem_addr`  out  28  line address, equal to `proc_addr[29:2]` of the missing access.
- `mem_wdata`  out  128  constant 0.
- `mem_ready`  in  1  one-cycle pulse; `mem_rdata` is valid in that cycle.
- `mem_rdata`  in  128  line data; word `k` is at `[32k+31:32k]`.

## Operation
- Storage per line: valid bit, tag, 128-bit data. Reset clears all valid bits. Tag and data are not reset.
- Hit condition: `valid[index] && tag[index] == proc_addr tag`.
- FSM has two states, IDLE and ALLOCATE. Reset state is IDLE.
- **IDLE:**
  - `proc_read=0`: `proc_stall=0`.
  - `proc_read=1`, hit: `proc_stall=0` and `proc_rdata` = selected word, both combinational in the same cycle.
  - `proc_read=1`, miss: `proc_stall=1`. On the next edge, latch `proc_addr[29:2]` into `miss_addr` and move to ALLOCATE.
- **ALLOCATE:**
  - `proc_stall=1`, `mem_read=1`, `mem_addr=miss_addr`.
  - When a `mem_ready` edge is seen: write `mem_rdata` into line `miss_addr[IW-1:0]`, set its tag, set valid=1, move to IDLE.
- Refill always uses the latched `miss_addr`, even if `proc_addr` changes during ALLOCATE.
- The next IDLE cycle re-evaluates the current `proc_addr`. If it matches the refilled line, it hits.
- `proc_write` and `proc_wdata` have no effect on state or outputs.
- A `mem_ready` pulse received while in IDLE is ignored.
- `proc_rdata` is don't-care while `proc_stall=1`. The implementation drives the selected word of the indexed line regardless.
- Conflict miss: refill overwrites the line unconditionally. There is no dirty state.

## Timing
- Reset values: `proc_stall=0` (when `proc_read=0`), `mem_read=0`, `mem_addr=0`, `mem_write=0`, `mem_wdata=0`, state IDLE.
- Hit latency: 0 cycles (combinational).
- Miss timeline, with the miss first seen in cycle T:
  - T: `proc_stall=1`.
  - T+1 onward: `mem_read=1`, held until and including the `mem_ready` cycle R.
  - R+1: IDLE, hit, `proc_stall=0`.
  - Penalty is `(R - T) + 1` stall cycles.
- `mem_read` and `mem_addr` are registered-state-derived and glitch-free. They change only on clock edges.
- `mem_read` drops in the cycle after `mem_ready`; it is never asserted in IDLE.
- Asynchronous reset mid-ALLOCATE: state returns to IDLE and `mem_read` drops immediately. All valid bits clear. The pending refill is abandoned.
- `DCACHE_stall` does not affect this block. The pipeline holds `proc_addr` while stalled.

## Test plan
- **Cold miss:** after reset, `proc_read=1`, `proc_addr=0x00000004`. Expect `proc_stall=1`; next cycle `mem_read=1`, `mem_addr=0x0000001`. Memory pulses `mem_ready` 3 cycles later with `mem_rdata=0x44443333_22221111_00000000_DEADBEEF`. One cycle later expect `proc_stall=0`, `proc_rdata=0xDEADBEEF`.
- **Same-line hits:** after the refill above, `proc_addr` 0x5, 0x6, 0x7 in consecutive cycles. Expect `proc_rdata` 0x00000000, 0x22221111, 0x44443333 with `proc_stall=0` and `mem_read=0` throughout.
- **Conflict miss (default `NUM_BLOCKS`):** `proc_addr=0x00000024` (same index 1, different tag). Expect a miss with `mem_addr=0x0000009`. After refill, a re-access of 0x04 misses again.
- **Address change during ALLOCATE:** miss on 0x08, then `proc_addr` switches to 0x0C while ALLOCATE is pending. Refill must go to line 2 with `mem_addr=0x0000002`. 0x0C then misses in IDLE.
- **Reset mid-refill:** assert `rst_n=0` while `mem_read=1`. Expect `mem_read=0` immediately. A later `mem_ready` pulse is ignored, and a re-access to the same address misses.
- **Ignored write:** `proc_write=1`, `proc_read=0`, any `proc_wdata`. Expect no stall and no memory activity; a subsequent hit returns the unchanged data.

Source files
------------

// File: rtl/icache_dm.sv
// icache_dm: read-only, direct-mapped instruction cache.
// Serves 32-bit instruction words to the fetch stage with zero added latency on a hit.
// On a miss it stalls and refills a full 128-bit (4-word) line from instruction memory.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   proc_read, proc_write    fetch request / write strobe (write is ignored)
//   proc_addr[29:0]          word address: [1:0] offset, [IW+1:2] index, [29:IW+2] tag
//   proc_wdata[31:0]         unused
//   proc_stall               high when proc_rdata is not valid this cycle
//   proc_rdata[31:0]         selected instruction word of the indexed line
//   mem_read, mem_addr[27:0] line refill request and line address (registered)
//   mem_write, mem_wdata     tied to zero
//   mem_ready, mem_rdata     one-cycle refill completion pulse and line data
module icache_dm #(
  parameter int unsigned NUM_BLOCKS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic         mem_ready,
  input  logic [127:0] mem_rdata
);

  localparam int unsigned IW   = $clog2(NUM_BLOCKS);
  localparam int unsigned TagW = 28 - IW;

  typedef enum logic {StIdle, StAlloc} state_e;

  state_e              state_q, state_d;
  logic [27:0]         miss_addr_q, miss_addr_d;
  logic [NUM_BLOCKS-1:0] valid_q, valid_d;
  logic [TagW-1:0]     tag_q  [NUM_BLOCKS];
  logic [127:0]        data_q [NUM_BLOCKS];

  logic [IW-1:0]       idx;
  logic [TagW-1:0]     proc_tag;
  logic [1:0]          word_sel;
  logic                hit;
  logic                fill;
  logic [IW-1:0]       fill_idx;
  logic [TagW-1:0]     fill_tag;

  // Writes are not supported; keep the tied-off inputs visibly consumed.
  logic unused_inputs;
  assign unused_inputs = ^{proc_write, proc_wdata};

  assign word_sel = proc_addr[1:0];
  assign idx      = proc_addr[IW+1:2];
  assign proc_tag = proc_addr[29:IW+2];
  assign hit      = valid_q[idx] && (tag_q[idx] == proc_tag);

  // Refill targets the latched miss address, never the live proc_addr.
  assign fill_idx = miss_addr_q[IW-1:0];
  assign fill_tag = miss_addr_q[27:IW];
  assign fill     = (state_q == StAlloc) && mem_ready;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    valid_d     = valid_q;
    unique case (state_q)
      StIdle: begin
        if (proc_read && !hit) begin
          state_d     = StAlloc;
          miss_addr_d = proc_addr[29:2];
        end
      end
      StAlloc: begin
        if (mem_ready) begin
          state_d           = StIdle;
          valid_d[fill_idx] = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      valid_q     <= valid_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_rdata;
    end
  end

  // Outputs. mem_read/mem_addr depend only on flops, so they move only on edges.
  assign proc_stall = (state_q == StAlloc) || (proc_read && !hit);
  assign proc_rdata = data_q[idx][{word_sel, 5'b0} +: 32];
  assign mem_read   = (state_q == StAlloc);
  assign mem_addr   = miss_addr_q;
  assign mem_write  = 1'b0;
  assign mem_wdata  = '0;

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm: expected fetch words are queued when a
// fetch is issued and popped when the cache returns the word without stalling.
module tb_icache_dm;

  logic         clk;
  logic         rst_n;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;

  icache_dm #(.NUM_BLOCKS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] LineA = 128'h44443333_22221111_00000000_DEADBEEF;
  localparam logic [127:0] LineB = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
  localparam logic [127:0] LineC = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
  localparam logic [127:0] LineD = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
  localparam logic [127:0] LineE = 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0;
  localparam logic [127:0] LineF = 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check32(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", name, obs, exp);
    end
  endtask

  // Drive a fetch just after the rising edge.
  task automatic drive(input logic rd, input logic [29:0] addr);
    @(posedge clk);
    #1;
    proc_read = rd;
    proc_addr = addr;
  endtask

  // Call at the negedge of a cycle where the word must be delivered.
  task automatic expect_out(input string name);
    logic [31:0] exp;
    check_bit({name, "_stall"}, proc_stall, 1'b0);
    n_cmp++;
    assert (exp_q.size() > 0) else begin
      n_err++;
      $error("FAIL %s_queue: observed empty scoreboard expected a pending word", name);
    end
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check32({name, "_rdata"}, proc_rdata, exp);
    end
  endtask

  // Entered at the negedge of miss cycle T; returns at the negedge of R+1.
  task automatic refill(input string name, input logic [27:0] exp_addr,
                        input logic [127:0] line, input int delay);
    @(negedge clk);
    check_bit({name, "_mem_read_t1"}, mem_read, 1'b1);
    check32({name, "_mem_addr"}, {4'b0, mem_addr}, {4'b0, exp_addr});
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check_bit({name, "_stall_wait"}, proc_stall, 1'b1);
    end
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    mem_rdata = line;
    @(negedge clk);
    check_bit({name, "_mem_read_r"}, mem_read, 1'b1);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    check_bit({name, "_mem_read_r1"}, mem_read, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;

    // Reset state
    #3;
    check_bit("rst_stall", proc_stall, 1'b0);
    check_bit("rst_mem_read", mem_read, 1'b0);
    check32("rst_mem_addr", {4'b0, mem_addr}, 32'h0);
    check_bit("rst_mem_write", mem_write, 1'b0);
    check_bit("rst_mem_wdata", |mem_wdata, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Cold miss on 0x4, ready three cycles after mem_read rises
    drive(1'b1, 30'h4);
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    check_bit("cold_stall_t", proc_stall, 1'b1);
    refill("cold", 28'h1, LineA, 2);
    expect_out("cold_hit");

    // Same-line hits
    drive(1'b1, 30'h5);
    exp_q.push_back(32'h00000000);
    @(negedge clk);
    expect_out("hit5");
    check_bit("hit5_mem_read", mem_read, 1'b0);
    drive(1'b1, 30'h6);
    exp_q.push_back(32'h22221111);
    @(negedge clk);
    expect_out("hit6");
    check_bit("hit6_mem_read", mem_read, 1'b0);
    drive(1'b1, 30'h7);
    exp_q.push_back(32'h44443333);
    @(negedge clk);
    expect_out("hit7");
    check_bit("hit7_mem_read", mem_read, 1'b0);

    // Conflict miss on index 1, then the evicted line misses again
    drive(1'b1, 30'h24);
    exp_q.push_back(LineB[31:0]);
    @(negedge clk);
    check_bit("conf_stall_t", proc_stall, 1'b1);
    refill("conf", 28'h9, LineB, 1);
    expect_out("conf_hit");
    drive(1'b1, 30'h4);
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    check_bit("evict_stall_t", proc_stall, 1'b1);
    refill("evict", 28'h1, LineA, 0);
    expect_out("evict_hit");

    // Address change during ALLOCATE: refill goes to line 2, then 0xC misses
    drive(1'b1, 30'h8);
    @(negedge clk);
    check_bit("chg_stall_t", proc_stall, 1'b1);
    drive(1'b1, 30'hC);
    exp_q.push_back(LineD[31:0]);
    refill("chg", 28'h2, LineC, 1);
    check_bit("chg_c_miss", proc_stall, 1'b1);
    refill("chg_c", 28'h3, LineD, 0);
    expect_out("chg_c_hit");
    drive(1'b1, 30'hA);
    exp_q.push_back(LineC[95:64]);
    @(negedge clk);
    expect_out("chg_line2_hit");

    // Ignored write: no stall, no memory activity, data unchanged
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b1;
    proc_addr  = 30'h8;
    proc_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    check_bit("wr_stall", proc_stall, 1'b0);
    check_bit("wr_mem_read", mem_read, 1'b0);
    @(posedge clk);
    #1;
    proc_write = 1'b0;
    proc_wdata = '0;
    proc_read  = 1'b1;
    exp_q.push_back(LineC[31:0]);
    @(negedge clk);
    expect_out("wr_after_hit");

    // Reset mid-refill
    drive(1'b1, 30'h10);
    @(negedge clk);
    check_bit("rstm_stall_t", proc_stall, 1'b1);
    @(negedge clk);
    check_bit("rstm_mem_read", mem_read, 1'b1);
    #2;
    rst_n     = 1'b0;
    proc_read = 1'b0;
    #1;
    check_bit("rstm_mem_read_drop", mem_read, 1'b0);
    check_bit("rstm_stall_drop", proc_stall, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    mem_rdata = LineF;
    @(negedge clk);
    check_bit("idle_ready_mem_read", mem_read, 1'b0);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    check_bit("idle_ready_state", mem_read, 1'b0);

    // Valid bits cleared: previously cached line misses
    drive(1'b1, 30'h8);
    @(negedge clk);
    check_bit("rstm_line2_miss", proc_stall, 1'b1);
    refill("rstm_line2", 28'h2, LineC, 0);
    drive(1'b1, 30'h10);
    exp_q.push_back(LineE[31:0]);
    @(negedge clk);
    check_bit("rstm_retry_miss", proc_stall, 1'b1);
    refill("rstm_retry", 28'h4, LineE, 1);
    expect_out("rstm_retry_hit");

    @(posedge clk);
    #1;
    proc_read = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
